// File: rtl/nano_rv32i_pkg.sv
// Shared constants and types for the nano_rv32i core front end.
package nano_rv32i_pkg;

    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_mode_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched instruction and its PC while decode stalls.
module fetch_skid_buf
    import nano_rv32i_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] ld_instr,
    input  logic [31:0] ld_pc,
    output logic        vld,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
        end else if (drain) begin
            vld <= 1'b0;
        end
    end

    // Payload carries no reset; it is only observed while vld is set.
    always_ff @(posedge clk_i) begin
        if (load) begin
            instr <= ld_instr;
            pc    <= ld_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, imem read issue, skid buffering and redirects.
// Optional misaligned-target halt is enabled by defining FETCH_MISALIGN_EN.
module fetch_unit
    import nano_rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_rd_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        misalign_o
);

    logic [31:0] fetch_pc_p0;
    logic        inflight_vld_p1;
    logic [31:0] inflight_pc_p1;
    logic        skid_vld;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    fetch_mode_e mode_q, mode_d;
    logic        misalign_q, misalign_d;
    logic        issue;
    logic        skid_load;
    logic        present_vld;
    logic [31:0] redirect_pc;

`ifdef FETCH_MISALIGN_EN
    logic tgt_misaligned;
    assign redirect_pc    = branch_target_i;
    assign tgt_misaligned = |branch_target_i[1:0];
`else
    logic unused_tgt_lsb;
    assign redirect_pc    = {branch_target_i[31:2], 2'b00};
    assign unused_tgt_lsb = ^branch_target_i[1:0];
`endif

    // Mode FSM: a misaligned redirect parks fetch until an aligned redirect or reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q     <= RUN;
            misalign_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        mode_d     = mode_q;
        misalign_d = misalign_q;
`ifdef FETCH_MISALIGN_EN
        if (branch_taken_i) begin
            if (tgt_misaligned) begin
                mode_d     = HALT;
                misalign_d = 1'b1;
            end else begin
                mode_d     = RUN;
                misalign_d = 1'b0;
            end
        end
`endif
    end

    assign misalign_o = misalign_q;

    // A new read may go out only if the word it returns has somewhere to land.
    assign issue = (mode_q == RUN) && !rst_i && !branch_taken_i &&
                   (instr_ready_i || (!skid_vld && !inflight_vld_p1));

    assign imem_rd_o   = issue;
    assign imem_addr_o = rst_i ? RESET_PC : fetch_pc_p0;

    // Stage p0 -> p1: fetch PC advances, issued address becomes the inflight tag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_p0     <= RESET_PC;
            inflight_vld_p1 <= 1'b0;
            inflight_pc_p1  <= RESET_PC;
        end else begin
            if (branch_taken_i) begin
                fetch_pc_p0 <= redirect_pc;
            end else if (issue) begin
                fetch_pc_p0 <= fetch_pc_p0 + PC_STEP;
            end
            inflight_vld_p1 <= issue;
            if (issue) begin
                inflight_pc_p1 <= fetch_pc_p0;
            end
        end
    end

    assign skid_load = inflight_vld_p1 && !instr_ready_i && !branch_taken_i;

    fetch_skid_buf u_skid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (skid_load),
        .drain    (instr_ready_i),
        .flush    (branch_taken_i),
        .ld_instr (imem_data_i),
        .ld_pc    (inflight_pc_p1),
        .vld      (skid_vld),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    // Stage p1 -> decode: skid has priority since it always holds the older word.
    assign present_vld   = (skid_vld || inflight_vld_p1) && !branch_taken_i && !rst_i &&
                           (mode_q == RUN);
    assign instr_valid_o = present_vld;
    assign instr_o       = !present_vld ? RV_NOP : (skid_vld ? skid_instr : imem_data_i);
    assign pc_o          = rst_i ? RESET_PC : (skid_vld ? skid_pc : inflight_pc_p1);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing scenarios plus a randomized stream check.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        ready;
    logic        br;
    logic [31:0] tgt;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    fetch_unit dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .imem_addr_o     (imem_addr),
        .imem_rd_o       (imem_rd),
        .imem_data_i     (imem_data),
        .instr_o         (instr),
        .pc_o            (pc),
        .instr_valid_o   (valid),
        .instr_ready_i   (ready),
        .branch_taken_i  (br),
        .branch_target_i (tgt),
        .misalign_o      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0: return 32'h0050_0093;
            32'h4: return 32'h0010_2223;
            32'h8: return 32'h0010_8093;
            default: return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= imem_word(imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs change just after posedge, outputs sampled at negedge.
    task automatic step(input logic r_rst, input logic r_rdy, input logic r_br, input logic [31:0] r_tgt);
        @(posedge clk);
        #1;
        rst   = r_rst;
        ready = r_rdy;
        br    = r_br;
        tgt   = r_tgt;
        @(negedge clk);
        check("skid_inflight_exclusive", {31'd0, dut.skid_vld & dut.inflight_vld_p1}, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("rst_rd", {31'd0, imem_rd}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_pc", pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
    endtask

    task automatic expect_word(input string tag, input logic [31:0] exp_pc);
        check({tag, "_valid"}, {31'd0, valid}, 32'd1);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_instr"}, instr, imem_word(exp_pc));
    endtask

    task automatic expect_bubble(input string tag);
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_nop"}, instr, NOP);
    endtask

    task automatic expect_issue(input string tag, input logic rd, input logic [31:0] addr);
        check({tag, "_rd"}, {31'd0, imem_rd}, {31'd0, rd});
        if (rd) check({tag, "_addr"}, imem_addr, addr);
    endtask

    logic [31:0] exp_pc;
    int          bubble;
    logic        r_rdy, r_br;
    logic [31:0] r_tgt;

    initial begin
        rst = 1'b1; ready = 1'b1; br = 1'b0; tgt = 32'h0;

        // Straight-line fetch with ready held high.
        do_reset();
        step(0, 1, 0, 0); expect_issue("a0", 1, 32'h0); expect_bubble("a0");
        step(0, 1, 0, 0); expect_word("a1", 32'h0); expect_issue("a1", 1, 32'h4);
        step(0, 1, 0, 0); expect_word("a2", 32'h4);
        step(0, 1, 0, 0); expect_word("a3", 32'h8);
        step(0, 1, 0, 0); expect_word("a4", 32'hC);

        // Decode stall on cycles 2-4.
        do_reset();
        step(0, 1, 0, 0);
        step(0, 1, 0, 0); expect_word("b1", 32'h0);
        step(0, 0, 0, 0); expect_word("b2", 32'h4); expect_issue("b2", 0, 0);
        step(0, 0, 0, 0); expect_word("b3", 32'h4); expect_issue("b3", 0, 0);
        step(0, 0, 0, 0); expect_word("b4", 32'h4); expect_issue("b4", 0, 0);
        step(0, 1, 0, 0); expect_word("b5", 32'h4); expect_issue("b5", 1, 32'h8);
        step(0, 1, 0, 0); expect_word("b6", 32'h8);
        step(0, 1, 0, 0); expect_word("b7", 32'hC);

        // Redirect at cycle 3.
        do_reset();
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'h10); expect_bubble("c3"); expect_issue("c3", 0, 0);
        step(0, 1, 0, 0); expect_bubble("c4"); expect_issue("c4", 1, 32'h10);
        step(0, 1, 0, 0); expect_word("c5", 32'h10);

        // Redirect while the skid holds a word.
        do_reset();
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h40); expect_bubble("d3");
        step(0, 1, 0, 0); expect_bubble("d4"); expect_issue("d4", 1, 32'h40);
        step(0, 1, 0, 0); expect_word("d5", 32'h40);

        // Reset in the middle of a stall drops buffered words.
        do_reset();
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0); expect_bubble("g_rst"); expect_issue("g_rst", 0, 0);
        step(0, 0, 0, 0); expect_bubble("g0"); expect_issue("g0", 1, 32'h0);
        step(0, 1, 0, 0); expect_word("g1", 32'h0);

        // PC wrap from the top of the address space.
        do_reset();
        step(0, 1, 1, 32'hFFFF_FFFC);
        step(0, 1, 0, 0); expect_issue("e1", 1, 32'hFFFF_FFFC);
        step(0, 1, 0, 0); expect_word("e2", 32'hFFFF_FFFC); expect_issue("e2", 1, 32'h0);
        step(0, 1, 0, 0); expect_word("e3", 32'h0);

        // Misaligned redirect target.
        do_reset();
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'h6); expect_bubble("f0");
`ifdef FETCH_MISALIGN_EN
        step(0, 1, 0, 0); expect_bubble("f1"); expect_issue("f1", 0, 0);
        check("f1_misalign", {31'd0, misalign}, 32'd1);
        step(0, 1, 0, 0); expect_bubble("f2"); expect_issue("f2", 0, 0);
        check("f2_misalign", {31'd0, misalign}, 32'd1);
        step(0, 1, 1, 32'h8); expect_issue("f3", 0, 0);
        step(0, 1, 0, 0); expect_issue("f4", 1, 32'h8);
        check("f4_misalign", {31'd0, misalign}, 32'd0);
        step(0, 1, 0, 0); expect_word("f5", 32'h8);
`else
        step(0, 1, 0, 0); expect_issue("f1", 1, 32'h4);
        check("f1_misalign", {31'd0, misalign}, 32'd0);
        step(0, 1, 0, 0); expect_word("f2", 32'h4);
`endif

        // Randomized stream: decode must see consecutive PCs from each redirect target.
        do_reset();
        exp_pc = 32'h0;
        bubble = 0;
        for (int i = 0; i < 3000; i++) begin
            r_rdy = ($urandom_range(0, 9) < 7);
            r_br  = ($urandom_range(0, 19) == 0);
            r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                : ($urandom & 32'h0000_0FFC);
`ifndef FETCH_MISALIGN_EN
            r_tgt = r_tgt | ($urandom & 32'h3);
`endif
            step(0, r_rdy, r_br, r_tgt);
            if (r_br) begin
                check("rnd_br_mask", {31'd0, valid}, 32'd0);
                exp_pc = r_tgt & ~32'h3;
                bubble = 0;
            end else if (valid) begin
                check("rnd_pc", pc, exp_pc);
                check("rnd_instr", instr, imem_word(exp_pc));
                if (r_rdy) exp_pc = exp_pc + 32'd4;
                bubble = 0;
            end else begin
                check("rnd_nop", instr, NOP);
                bubble++;
                check("rnd_bubble_run", {31'd0, bubble > 1}, 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
